plic_nsrc: RTL

Parametrised platform-level interrupt controller for one hart target with NSRC peripheral interrupt sources. It sits on the peripheral Wishbone bus beside the GPIO and UART blocks and drives the core's machine external interrupt line. Compared with the two-source controller, it adds:
- per-source programmable priority of configurable width;
- a readable pending bitmap;
- lowest-ID tie-breaking;
- an optional edge-triggered gateway mode.

---
 rtl/plic_nsrc.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/plic_nsrc.sv
// plic_nsrc: platform-level interrupt controller, one hart target, NSRC sources.
// Wishbone classic slave; registered external interrupt output.
// Optional build macro PLIC_EDGE_TRIG_EN selects edge-triggered gateways with a
// one-deep missed-edge flag per source; level-triggered gateways otherwise.
module plic_nsrc #(
    parameter int NSRC   = 8,
    parameter int PRIO_W = 3,
    parameter int AW     = 32,
    parameter int DW     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NSRC-1:0]   src_irq_i,
    output logic              plic_core_ext_irq_o,
    input  logic              wbm_plic_cyc_i,
    input  logic              wbm_plic_stb_i,
    input  logic              wbm_plic_we_i,
    input  logic [AW-1:0]     wbm_plic_addr_i,
    input  logic [DW-1:0]     wbm_plic_wdata_i,
    input  logic [DW/8-1:0]   wbm_plic_sel_i,
    output logic [DW-1:0]     plic_wbm_rdata_o,
    output logic              plic_wbm_ack_o
);

    localparam int IDW = 5;
    localparam logic [9:0] WORD_PENDING = 10'h020;
    localparam logic [9:0] WORD_ENABLE  = 10'h040;
    localparam logic [9:0] WORD_THRESH  = 10'h080;
    localparam logic [9:0] WORD_CLAIM   = 10'h081;
    localparam logic [PRIO_W-1:0] PRIO_RST = PRIO_W'(32'd1);

    // Registered state
    logic [PRIO_W-1:0] prio_q [1:NSRC];
    logic [PRIO_W-1:0] prio_d [1:NSRC];
    logic [NSRC:1]     enable_q, enable_d;
    logic [PRIO_W-1:0] thr_q, thr_d;
    logic [NSRC:1]     ip_q, ip_d;
    logic [NSRC:1]     busy_q, busy_d;
    logic              ack_q, ack_d;
    logic [DW-1:0]     rdata_q, rdata_d;
    logic              ext_irq_q, ext_irq_d;
`ifdef PLIC_EDGE_TRIG_EN
    logic [NSRC:1]     prev_q, prev_d;
    logic [NSRC:1]     missed_q, missed_d;
    logic [NSRC:1]     rise_s;
`endif

    // Combinational helpers
    logic [NSRC:1]     src_s;
    logic [9:0]        word_s;
    logic              req_s;
    logic              claim_s;
    logic              cpl_s;
    logic [IDW-1:0]    cpl_id_s;
    logic [IDW-1:0]    winner_s;
    logic [PRIO_W-1:0] best_s;
    logic [NSRC:1]     eligible_s;
    logic [NSRC:1]     claim_clr_s;
    logic [NSRC:1]     cpl_hit_s;
    logic              unused_s;

    assign src_s    = src_irq_i;
    assign word_s   = wbm_plic_addr_i[11:2];
    assign req_s    = wbm_plic_cyc_i & wbm_plic_stb_i & ~ack_q;
    assign cpl_id_s = wbm_plic_wdata_i[IDW-1:0];
    assign unused_s = ^{wbm_plic_sel_i, wbm_plic_addr_i, wbm_plic_wdata_i};

    // Arbitration: highest priority above threshold wins, strict compare keeps lowest ID on ties
    always_comb begin
        winner_s   = {IDW{1'b0}};
        best_s     = {PRIO_W{1'b0}};
        eligible_s = {NSRC{1'b0}};
        for (int k = 1; k <= NSRC; k++) begin
            eligible_s[k] = ip_q[k] & enable_q[k] & (prio_q[k] > thr_q);
            if (eligible_s[k] && (prio_q[k] > best_s)) begin
                best_s   = prio_q[k];
                winner_s = k[IDW-1:0];
            end else begin
                best_s   = best_s;
                winner_s = winner_s;
            end
        end
    end

    // Bus decode: register writes, read data mux, claim/complete strobes
    always_comb begin
        ack_d    = 1'b0;
        rdata_d  = rdata_q;
        enable_d = enable_q;
        thr_d    = thr_q;
        prio_d   = prio_q;
        claim_s  = 1'b0;
        cpl_s    = 1'b0;
        if (req_s) begin
            ack_d = 1'b1;
            if (wbm_plic_we_i) begin
                case (word_s)
                    WORD_ENABLE: enable_d = wbm_plic_wdata_i[NSRC:1];
                    WORD_THRESH: thr_d    = wbm_plic_wdata_i[PRIO_W-1:0];
                    WORD_CLAIM:  cpl_s    = 1'b1;
                    default: begin
                        for (int k = 1; k <= NSRC; k++) begin
                            if (word_s == k[9:0]) begin
                                prio_d[k] = wbm_plic_wdata_i[PRIO_W-1:0];
                            end else begin
                                prio_d[k] = prio_q[k];
                            end
                        end
                    end
                endcase
            end else begin
                rdata_d = {DW{1'b0}};
                case (word_s)
                    WORD_PENDING: rdata_d[NSRC:1]     = ip_q;
                    WORD_ENABLE:  rdata_d[NSRC:1]     = enable_q;
                    WORD_THRESH:  rdata_d[PRIO_W-1:0] = thr_q;
                    WORD_CLAIM: begin
                        rdata_d[IDW-1:0] = winner_s;
                        claim_s          = 1'b1;
                    end
                    default: begin
                        for (int k = 1; k <= NSRC; k++) begin
                            if (word_s == k[9:0]) begin
                                rdata_d[PRIO_W-1:0] = prio_q[k];
                            end else begin
                                rdata_d = rdata_d;
                            end
                        end
                    end
                endcase
            end
        end else begin
            ack_d = 1'b0;
        end
    end

    // Gateways: capture requests into ip/busy, apply claim clears and completes
    always_comb begin
        ip_d        = ip_q;
        busy_d      = busy_q;
        claim_clr_s = {NSRC{1'b0}};
        cpl_hit_s   = {NSRC{1'b0}};
`ifdef PLIC_EDGE_TRIG_EN
        prev_d   = src_s;
        missed_d = missed_q;
        rise_s   = src_s & ~prev_q;
`endif
        for (int k = 1; k <= NSRC; k++) begin
            claim_clr_s[k] = claim_s & (winner_s == k[IDW-1:0]);
            cpl_hit_s[k]   = cpl_s & (cpl_id_s == k[IDW-1:0]) & busy_q[k];
            // a claimed source is always busy, so the clear never races a fresh capture
            ip_d[k] = ip_q[k] & ~claim_clr_s[k];
`ifdef PLIC_EDGE_TRIG_EN
            if (cpl_hit_s[k]) begin
                if (missed_q[k] || rise_s[k]) begin
                    // replay the held-back edge: source stays busy and becomes pending
                    ip_d[k]     = 1'b1;
                    busy_d[k]   = 1'b1;
                    missed_d[k] = missed_q[k] & rise_s[k];
                end else begin
                    busy_d[k]   = 1'b0;
                    missed_d[k] = 1'b0;
                end
            end else if (rise_s[k]) begin
                if (!busy_q[k]) begin
                    ip_d[k]   = 1'b1;
                    busy_d[k] = 1'b1;
                end else begin
                    // one-deep: a second edge while already missed is dropped
                    missed_d[k] = 1'b1;
                end
            end else begin
                missed_d[k] = missed_q[k];
            end
`else
            if (cpl_hit_s[k]) begin
                // complete wins over a same-cycle capture; a held level re-captures next cycle
                busy_d[k] = 1'b0;
            end else if (src_s[k] && !busy_q[k]) begin
                ip_d[k]   = 1'b1;
                busy_d[k] = 1'b1;
            end else begin
                busy_d[k] = busy_q[k];
            end
`endif
        end
    end

    // Interrupt line follows the arbitration result one cycle later
    always_comb begin
        if (winner_s != {IDW{1'b0}}) begin
            ext_irq_d = 1'b1;
        end else begin
            ext_irq_d = 1'b0;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 1; k <= NSRC; k++) begin
                prio_q[k] <= PRIO_RST;
            end
            enable_q  <= {NSRC{1'b0}};
            thr_q     <= {PRIO_W{1'b0}};
            ip_q      <= {NSRC{1'b0}};
            busy_q    <= {NSRC{1'b0}};
            ack_q     <= 1'b0;
            rdata_q   <= {DW{1'b0}};
            ext_irq_q <= 1'b0;
`ifdef PLIC_EDGE_TRIG_EN
            prev_q    <= {NSRC{1'b0}};
            missed_q  <= {NSRC{1'b0}};
`endif
        end else begin
            prio_q    <= prio_d;
            enable_q  <= enable_d;
            thr_q     <= thr_d;
            ip_q      <= ip_d;
            busy_q    <= busy_d;
            ack_q     <= ack_d;
            rdata_q   <= rdata_d;
            ext_irq_q <= ext_irq_d;
`ifdef PLIC_EDGE_TRIG_EN
            prev_q    <= prev_d;
            missed_q  <= missed_d;
`endif
        end
    end

    assign plic_core_ext_irq_o = ext_irq_q;
    assign plic_wbm_ack_o      = wbm_plic_cyc_i & ack_q;
    assign plic_wbm_rdata_o    = rdata_q;

endmodule
